// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: shares one 2-way two-level cache between two requesters.
// A round-robin arbiter picks one read at a time. That read gets one cache_read
// pulse. The cache hit flags then choose a latency class (L1, L2 or memory), and
// the matching penalty runs before a tagged response is returned.
// Optional feature: define CACHE_ARB_STATS_EN to add saturating per-level
// hit counters (stat_l1_cnt, stat_l2_cnt, stat_mem_cnt).
module cache_req_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned L2_PENALTY  = 2,
  parameter int unsigned MEM_PENALTY = 8
`ifdef CACHE_ARB_STATS_EN
  ,
  parameter int unsigned STAT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [1:0]            resp_level,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_read,
  input  logic [DATA_WIDTH-1:0] cache_read_data,
  input  logic                  cache_l1_hit,
  input  logic                  cache_l2_hit,
`ifdef CACHE_ARB_STATS_EN
  output logic [STAT_WIDTH-1:0] stat_l1_cnt,
  output logic [STAT_WIDTH-1:0] stat_l2_cnt,
  output logic [STAT_WIDTH-1:0] stat_mem_cnt,
`endif
  output logic                  busy
);

  // The counter only has to hold the largest penalty. Keep at least one bit.
  localparam int unsigned CNT_W = (MEM_PENALTY > 0) ? $clog2(MEM_PENALTY + 1) : 1;

  localparam logic [CNT_W-1:0] PEN_L2  = CNT_W'(L2_PENALTY);
  localparam logic [CNT_W-1:0] PEN_MEM = CNT_W'(MEM_PENALTY);
  localparam logic [CNT_W-1:0] PEN_ONE = CNT_W'(1);

  localparam logic [1:0] LVL_L1  = 2'd0;
  localparam logic [1:0] LVL_L2  = 2'd1;
  localparam logic [1:0] LVL_MEM = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PENALTY,
    S_RESP
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             id_q;
  logic [CNT_W-1:0] pen_cnt;
  logic [1:0]       wait_level;
  logic [CNT_W-1:0] wait_pen;

  // Grant: a lone requester wins. On a tie the one not served last wins.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == S_IDLE) begin
      req0_ready = req0_valid && (!req1_valid || last_grant);
      req1_ready = req1_valid && (!req0_valid || !last_grant);
    end
  end

  // Classify the cache result. An L1 hit takes priority when both flags are set.
  always_comb begin
    wait_level = LVL_MEM;
    wait_pen   = PEN_MEM;
    if (cache_l1_hit) begin
      wait_level = LVL_L1;
      wait_pen   = '0;
    end else if (cache_l2_hit) begin
      wait_level = LVL_L2;
      wait_pen   = PEN_L2;
    end
  end

  // Request sequencing FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      pen_cnt    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_level <= LVL_L1;
      cache_addr <= '0;
      cache_read <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0_ready || req1_ready) begin
            id_q       <= req1_ready;
            last_grant <= req1_ready;
            cache_addr <= req1_ready ? req1_addr : req0_addr;
            cache_read <= 1'b1;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cache_read <= 1'b0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          resp_data  <= cache_read_data;
          resp_level <= wait_level;
          resp_id    <= id_q;
          pen_cnt    <= wait_pen;
          if (wait_pen == '0) begin
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            state      <= S_PENALTY;
          end
        end
        S_PENALTY: begin
          pen_cnt <= pen_cnt - PEN_ONE;
          if (pen_cnt <= PEN_ONE) begin
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          cache_read <= 1'b0;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_ARB_STATS_EN
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

  // Per-level result counters. Each one stops at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_l1_cnt  <= '0;
      stat_l2_cnt  <= '0;
      stat_mem_cnt <= '0;
    end else if (state == S_WAIT) begin
      case (wait_level)
        LVL_L1:  if (stat_l1_cnt  != '1) stat_l1_cnt  <= stat_l1_cnt  + STAT_ONE;
        LVL_L2:  if (stat_l2_cnt  != '1) stat_l2_cnt  <= stat_l2_cnt  + STAT_ONE;
        default: if (stat_mem_cnt != '1) stat_mem_cnt <= stat_mem_cnt + STAT_ONE;
      endcase
    end
  end
`endif

endmodule
